vr_pattern_producer: RTL and testbench
======================================

// Module: vr_pattern_producer
// PURPOSE
//  Parametrised valid/ready traffic source: next generation of the fixed 8-bit counting producer.
//  Emits bursts of BURST_LEN beats separated by GAP idle cycles.
//  Payload is an incrementing counter or an LFSR sequence, selected at run time.
//  Drives consumer/FIFO test fabrics; counts accepted beats for scoreboards.
// PARAMETERS
//  W        8      payload width (>=2)
//  GAP      4      valid-low cycles after each completed burst (0 = continuous)
//  BURST    1      beats per burst (>=1)
//  SEED     0      payload reset value
//  POLY     8'hB8  Galois LFSR feedback mask, W bits
//  CNT_W    16     accepted-beat counter width
//  TIMEOUT  16     stall limit in cycles (used only with VR_PROD_TIMEOUT_EN)
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset: synchronous, active-high
//  en         in   1      run enable
//  mode       in   1      0 = counter payload, 1 = LFSR payload
//  rdy        in   1      consumer ready
//  valid      out  1      payload valid
//  data       out  W      payload
//  beat_cnt   out  CNT_W  accepted beats, wraps at 2**CNT_W
//  burst_done out  1      1-cycle pulse in the cycle after the last beat of a burst is accepted
//  timeout    out  1      sticky stall flag (tied 0 unless VR_PROD_TIMEOUT_EN is defined)
// BEHAVIOUR
//  Reset values: state = IDLE; valid = 0; beat_cnt = 0; burst_done = 0; timeout = 0.
//  Reset data: SEED, except SEED==0 with mode=1 at reset loads 1 (LFSR never all-zero).
//  Transfer: occurs in any cycle with valid && rdy.
//  Valid hold: once valid rises, it stays high and data/mode stay frozen until the transfer.
//  en or mode changes while valid=1 take effect only after the transfer.
//  State IDLE: valid = 0; en = 1 -> SEND next cycle.
//  State SEND: valid = 1. On transfer, evaluate in order:
//   - beat < BURST-1: stay SEND (back-to-back, 1 beat/cycle with rdy = 1).
//   - last beat, en = 0: -> IDLE.
//   - last beat, GAP = 0: stay SEND.
//   - otherwise: -> WAIT, gap counter loaded with GAP-1.
//  State WAIT: valid = 0; counter decrements; at 0 -> SEND if en = 1, else -> IDLE.
//  Payload update (on transfer only):
//   - mode 0: data <= data + 1, wraps mod 2**W.
//   - mode 1: data <= (data >> 1) ^ (data[0] ? POLY : 0).
//   - mode 1 with data == 0: next value is 1.
//  Burst beat index: resets to 0 on entry to IDLE, and on the last beat of each burst.
//  beat_cnt: +1 per transfer; wraps from 2**CNT_W-1 to 0.
//  burst_done: registered pulse in the cycle after the last beat of each burst is accepted.
//  rst mid-burst: returns to IDLE with all reset values next cycle; partial burst is abandoned.
// CONFIGURATION
//  VR_PROD_TIMEOUT_EN defined:
//   - stall counter counts cycles with valid && !rdy; clears on every transfer.
//   - stall counter reaching TIMEOUT sets timeout = 1; it stays set until rst.
//   - handshake behaviour is unchanged.
//  VR_PROD_TIMEOUT_EN undefined: no stall counter is built; timeout is constant 0.
// TESTING
//  1. GAP=4, BURST=1, mode 0, rdy=1, en=1:
//     valid high 1 cycle then low 4; data 0,1,2,3; burst_done after each beat.
//  2. BURST=3, GAP=2, rdy=1:
//     3 consecutive valid cycles (data n..n+2), 2 low, repeat; beat_cnt +3 per burst.
//  3. rdy held 0 for 10 cycles, then 1:
//     valid stays 1 with data unchanged all 10 cycles; single transfer; beat_cnt +1.
//  4. mode=1, SEED=0, W=8, POLY=B8, rdy=1, GAP=0:
//     data 01,B8,5C,2E,17,B3; value 00 never appears.
//  5. en dropped, or mode toggled, while valid high and rdy=0:
//     valid held until rdy=1; then en=0 -> IDLE, mode applies to the next payload.
//     rst asserted mid-burst -> valid=0, beat_cnt=0 the next cycle.
//  6. VR_PROD_TIMEOUT_EN, TIMEOUT=16, rdy=0:
//     timeout rises after 16 stalled cycles and remains 1 after rdy returns, until rst.

Source files
------------

// File: rtl/vr_pattern_producer.sv
// vr_pattern_producer: parametrised valid/ready traffic source.
// It sends bursts of BURST beats with GAP idle cycles after each burst.
// The payload is either an incrementing counter or a Galois LFSR, chosen by
// the mode input. It also counts accepted beats for scoreboards.
// Optional build macro: VR_PROD_TIMEOUT_EN adds a sticky stall-timeout flag.
// Without the macro no stall counter is built and timeout is tied to 0.
module vr_pattern_producer #(
  parameter int              W       = 8,
  parameter int              GAP     = 4,
  parameter int              BURST   = 1,
  parameter logic [W-1:0]    SEED    = '0,
  parameter logic [W-1:0]    POLY    = 'hB8,
  parameter int              CNT_W   = 16,
  parameter int              TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             rdy,
  output logic             valid,
  output logic [W-1:0]     data,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             burst_done,
  output logic             timeout
);

  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t              state_q;
  logic                valid_q;
  logic [W-1:0]        data_q;
  logic [W-1:0]        data_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [GAP_W-1:0]    gap_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic                burst_done_q;

  // Next payload value. The beat on the bus is already fixed. The mode value
  // sampled at the transfer decides how the next payload is formed.
  // An all-zero LFSR state is replaced by 1 so the sequence cannot lock up.
  always_comb begin
    data_d = data_q;
    if (mode) begin
      if (data_q == '0) begin
        data_d = W'(1);
      end else begin
        data_d = (data_q >> 1) ^ (data_q[0] ? POLY : '0);
      end
    end else begin
      data_d = data_q + W'(1);
    end
  end

  // Burst/gap FSM with registered handshake outputs. Valid stays high in
  // SEND until a transfer happens. en is only checked at burst boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      data_q       <= ((SEED == '0) && mode) ? W'(1) : SEED;
      beat_q       <= '0;
      gap_q        <= '0;
      beat_cnt_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (en) begin
            state_q <= SEND;
            valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (rdy) begin
            data_q     <= data_d;
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (beat_q != LAST_BEAT) begin
              beat_q <= beat_q + BEAT_W'(1);
            end else begin
              beat_q       <= '0;
              burst_done_q <= 1'b1;
              if (!en) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
              end else if (GAP == 0) begin
                state_q <= SEND;
                valid_q <= 1'b1;
              end else begin
                state_q <= WAIT;
                valid_q <= 1'b0;
                gap_q   <= GAP_LOAD;
              end
            end
          end
        end
        WAIT: begin
          if (gap_q == '0) begin
            if (en) begin
              state_q <= SEND;
              valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VR_PROD_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_q;
  logic               timeout_q;

  // Count stalled cycles since the last transfer. The flag is sticky until
  // rst, so a stall that later clears is still visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else if (valid_q && rdy) begin
      stall_q <= '0;
    end else if (valid_q && !rdy) begin
      if (stall_q != STALL_W'(TIMEOUT)) begin
        stall_q <= stall_q + STALL_W'(1);
      end
      if (stall_q == STALL_W'(TIMEOUT - 1)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign valid      = valid_q;
  assign data       = data_q;
  assign beat_cnt   = beat_cnt_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_vr_pattern_producer.sv
// Directed testbench for vr_pattern_producer.
// Three instances cover different burst/gap shapes:
//   dutA: GAP=4 BURST=1, dutB: GAP=2 BURST=3 SEED=FE, dutC: GAP=0 CNT_W=4.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_vr_pattern_producer;

  logic clk;
  logic rst;

  logic enA, modeA, rdyA, validA, doneA, toA;
  logic [7:0]  dataA;
  logic [15:0] cntA;

  logic enB, modeB, rdyB, validB, doneB, toB;
  logic [7:0]  dataB;
  logic [15:0] cntB;

  logic enC, modeC, rdyC, validC, doneC, toC;
  logic [7:0] dataC;
  logic [3:0] cntC;

  int totalChecks = 0;
  int badChecks   = 0;
  logic expTimeout;

  logic [7:0] lfsrExp [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

  vr_pattern_producer #(
    .W(8), .GAP(4), .BURST(1), .SEED(8'h00), .POLY(8'hB8), .CNT_W(16), .TIMEOUT(16)
  ) dutA (
    .clk(clk), .rst(rst), .en(enA), .mode(modeA), .rdy(rdyA),
    .valid(validA), .data(dataA), .beat_cnt(cntA), .burst_done(doneA), .timeout(toA)
  );

  vr_pattern_producer #(
    .W(8), .GAP(2), .BURST(3), .SEED(8'hFE), .POLY(8'hB8), .CNT_W(16), .TIMEOUT(16)
  ) dutB (
    .clk(clk), .rst(rst), .en(enB), .mode(modeB), .rdy(rdyB),
    .valid(validB), .data(dataB), .beat_cnt(cntB), .burst_done(doneB), .timeout(toB)
  );

  vr_pattern_producer #(
    .W(8), .GAP(0), .BURST(1), .SEED(8'h00), .POLY(8'hB8), .CNT_W(4), .TIMEOUT(16)
  ) dutC (
    .clk(clk), .rst(rst), .en(enC), .mode(modeC), .rdy(rdyC),
    .valid(validC), .data(dataC), .beat_cnt(cntC), .burst_done(doneC), .timeout(toC)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to the falling edge n cycles later.
  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One comparison: count it, and report it if it fails.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) else begin
      badChecks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence of all scenarios.
  initial begin
`ifdef VR_PROD_TIMEOUT_EN
    expTimeout = 1'b1;
`else
    expTimeout = 1'b0;
`endif
    rst = 1'b1;
    enA = 1'b0; modeA = 1'b0; rdyA = 1'b1;
    enB = 1'b0; modeB = 1'b0; rdyB = 1'b1;
    enC = 1'b0; modeC = 1'b1; rdyC = 1'b1;
    waitCycles(2);

    // Reset values
    checkOutput("rst_validA", {31'd0, validA}, 32'd0);
    checkOutput("rst_dataA", {24'd0, dataA}, 32'h00);
    checkOutput("rst_cntA", {16'd0, cntA}, 32'd0);
    checkOutput("rst_doneA", {31'd0, doneA}, 32'd0);
    checkOutput("rst_toA", {31'd0, toA}, 32'd0);
    checkOutput("rst_dataB_seed", {24'd0, dataB}, 32'hFE);
    checkOutput("rst_dataC_lfsr1", {24'd0, dataC}, 32'h01);

    // Single-beat bursts with four idle cycles between them
    $display("[TB] single-beat bursts, GAP=4");
    rst = 1'b0;
    enA = 1'b1;
    waitCycles(1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("b1_valid_hi", {31'd0, validA}, 32'd1);
      checkOutput("b1_data", {24'd0, dataA}, 32'(k));
      checkOutput("b1_done_lo", {31'd0, doneA}, 32'd0);
      waitCycles(1);
      checkOutput("b1_valid_lo", {31'd0, validA}, 32'd0);
      checkOutput("b1_done_pulse", {31'd0, doneA}, 32'd1);
      checkOutput("b1_cnt", {16'd0, cntA}, 32'(k + 1));
      for (int g = 0; g < 3; g++) begin
        waitCycles(1);
        checkOutput("b1_gap_valid", {31'd0, validA}, 32'd0);
        checkOutput("b1_gap_done", {31'd0, doneA}, 32'd0);
      end
      waitCycles(1);
    end
    checkOutput("b1_data4", {24'd0, dataA}, 32'h04);
    enA = 1'b0;
    waitCycles(1);
    checkOutput("b1_en0_valid", {31'd0, validA}, 32'd0);
    checkOutput("b1_en0_cnt", {16'd0, cntA}, 32'd5);
    waitCycles(1);
    checkOutput("b1_idle_valid", {31'd0, validA}, 32'd0);

    // Three-beat bursts with counter wrap FE,FF,00 inside the first burst
    $display("[TB] three-beat bursts, GAP=2");
    enB = 1'b1;
    waitCycles(1);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("b3_valid_hi", {31'd0, validB}, 32'd1);
        checkOutput("b3_data", {24'd0, dataB}, {24'd0, 8'(8'hFE + 3 * b + i)});
        checkOutput("b3_done_lo", {31'd0, doneB}, 32'd0);
        waitCycles(1);
      end
      checkOutput("b3_gap_valid0", {31'd0, validB}, 32'd0);
      checkOutput("b3_done_pulse", {31'd0, doneB}, 32'd1);
      checkOutput("b3_cnt", {16'd0, cntB}, 32'(3 * (b + 1)));
      waitCycles(1);
      checkOutput("b3_gap_valid1", {31'd0, validB}, 32'd0);
      checkOutput("b3_gap_done1", {31'd0, doneB}, 32'd0);
      waitCycles(1);
    end
    // en dropped on the first beat: the burst still completes
    checkOutput("b3_data04", {24'd0, dataB}, 32'h04);
    enB = 1'b0;
    waitCycles(1);
    checkOutput("b3_en0_beat1", {24'd0, dataB}, 32'h05);
    checkOutput("b3_en0_valid1", {31'd0, validB}, 32'd1);
    waitCycles(1);
    checkOutput("b3_en0_beat2", {24'd0, dataB}, 32'h06);
    waitCycles(1);
    checkOutput("b3_en0_idle", {31'd0, validB}, 32'd0);
    checkOutput("b3_en0_cnt", {16'd0, cntB}, 32'd9);
    waitCycles(2);
    checkOutput("b3_en0_stay_idle", {31'd0, validB}, 32'd0);

    // Stall with rdy low for ten cycles
    $display("[TB] stall for 10 cycles");
    rdyA = 1'b0;
    enA  = 1'b1;
    waitCycles(1);
    for (int s = 0; s < 10; s++) begin
      checkOutput("stall_valid", {31'd0, validA}, 32'd1);
      checkOutput("stall_data", {24'd0, dataA}, 32'h05);
      checkOutput("stall_cnt", {16'd0, cntA}, 32'd5);
      waitCycles(1);
    end
    rdyA = 1'b1;
    waitCycles(1);
    checkOutput("stall_xfer_valid", {31'd0, validA}, 32'd0);
    checkOutput("stall_xfer_cnt", {16'd0, cntA}, 32'd6);
    checkOutput("stall_xfer_data", {24'd0, dataA}, 32'h06);
    checkOutput("stall_short_to", {31'd0, toA}, 32'd0);
    enA = 1'b0;
    waitCycles(5);
    checkOutput("stall_idle", {31'd0, validA}, 32'd0);

    // en and mode changed while valid is held by rdy=0
    $display("[TB] en/mode change during hold");
    rdyA = 1'b0;
    enA  = 1'b1;
    waitCycles(1);
    checkOutput("hold_valid_rise", {31'd0, validA}, 32'd1);
    enA   = 1'b0;
    modeA = 1'b1;
    for (int h = 0; h < 3; h++) begin
      waitCycles(1);
      checkOutput("hold_valid", {31'd0, validA}, 32'd1);
      checkOutput("hold_data", {24'd0, dataA}, 32'h06);
    end
    rdyA = 1'b1;
    waitCycles(1);
    checkOutput("hold_idle", {31'd0, validA}, 32'd0);
    checkOutput("hold_next_lfsr", {24'd0, dataA}, 32'h03);
    checkOutput("hold_cnt", {16'd0, cntA}, 32'd7);
    enA = 1'b1;
    waitCycles(1);
    checkOutput("hold_resend", {31'd0, validA}, 32'd1);
    waitCycles(1);
    checkOutput("hold_lfsr_tap", {24'd0, dataA}, 32'hB9);
    enA = 1'b0;

    // Reset mid-burst abandons the partial burst
    $display("[TB] reset mid-burst");
    enB = 1'b1;
    waitCycles(1);
    checkOutput("mid_beat0", {24'd0, dataB}, 32'h07);
    waitCycles(1);
    checkOutput("mid_beat1", {24'd0, dataB}, 32'h08);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("mid_rst_valid", {31'd0, validB}, 32'd0);
    checkOutput("mid_rst_cnt", {16'd0, cntB}, 32'd0);
    checkOutput("mid_rst_data", {24'd0, dataB}, 32'hFE);
    checkOutput("mid_rst_cntA", {16'd0, cntA}, 32'd0);
    checkOutput("mid_rst_dataA_lfsr1", {24'd0, dataA}, 32'h01);
    rst = 1'b0;
    waitCycles(1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("mid_full_valid", {31'd0, validB}, 32'd1);
      waitCycles(1);
    end
    checkOutput("mid_full_end", {31'd0, validB}, 32'd0);
    checkOutput("mid_full_cnt", {16'd0, cntB}, 32'd3);
    enB = 1'b0;

    // LFSR payload, continuous traffic, 4-bit beat counter wrap
    $display("[TB] LFSR continuous, GAP=0");
    enC = 1'b1;
    waitCycles(1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("lfsr_valid", {31'd0, validC}, 32'd1);
      checkOutput("lfsr_data", {24'd0, dataC}, {24'd0, lfsrExp[i]});
      checkOutput("lfsr_cnt", {28'd0, cntC}, 32'(i));
      waitCycles(1);
      checkOutput("lfsr_done", {31'd0, doneC}, 32'd1);
    end
    for (int j = 0; j < 10; j++) begin
      checkOutput("lfsr_nonzero", {31'd0, (dataC == 8'h00)}, 32'd0);
      checkOutput("lfsr_valid_cont", {31'd0, validC}, 32'd1);
      waitCycles(1);
      if (j == 8) checkOutput("lfsr_cnt_max", {28'd0, cntC}, 32'hF);
    end
    checkOutput("lfsr_cnt_wrap", {28'd0, cntC}, 32'd0);
    enC = 1'b0;
    waitCycles(1);
    checkOutput("lfsr_stop", {31'd0, validC}, 32'd0);

    // Long stall: the sticky timeout flag exists only with the macro defined
    $display("[TB] long stall");
    rdyA = 1'b0;
    enA  = 1'b1;
    waitCycles(1);
    waitCycles(15);
    checkOutput("to_before", {31'd0, toA}, 32'd0);
    waitCycles(1);
    checkOutput("to_rise", {31'd0, toA}, {31'd0, expTimeout});
    rdyA = 1'b1;
    enA  = 1'b0;
    waitCycles(4);
    checkOutput("to_sticky", {31'd0, toA}, {31'd0, expTimeout});
    checkOutput("to_valid_after", {31'd0, validA}, 32'd0);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("to_rst_clear", {31'd0, toA}, 32'd0);
    rst = 1'b0;
    waitCycles(1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
